// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game display path: object codes,
// grid size, LCD command bytes, tile update record and the colour lookup.
package snake_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;

  typedef logic [2:0] obj_code_t;

  localparam obj_code_t OBJ_EMPTY  = 3'b000;
  localparam obj_code_t OBJ_HEAD   = 3'b001;
  localparam obj_code_t OBJ_BODY   = 3'b010;
  localparam obj_code_t OBJ_APPLE  = 3'b011;
  localparam obj_code_t OBJ_BORDER = 3'b100;

  // LCD controller command bytes (column window, row window, memory write)
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // One buffered tile update
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    obj_code_t  obj;
  } tile_upd_t;

  localparam int TILE_UPD_W = $bits(tile_upd_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_C,
    ST_CASET_D,
    ST_RASET_C,
    ST_RASET_D,
    ST_RAMWR_C,
    ST_PIXEL
  } rend_state_e;

  // RGB565 colour for each object; unused codes render black
  function automatic logic [15:0] colour_lut(input obj_code_t code);
    case (code)
      OBJ_HEAD:   colour_lut = 16'h07E0;
      OBJ_BODY:   colour_lut = 16'h03E0;
      OBJ_APPLE:  colour_lut = 16'hF800;
      OBJ_BORDER: colour_lut = 16'hFFFF;
      default:    colour_lut = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/tile_fifo.sv
// Small synchronous FIFO for tile updates. Push and pop may coincide, which
// also lets a push land while the FIFO is full provided a pop frees a slot.
module tile_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  // Pointer and occupancy update
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the pointers and count decide what is valid.
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tile_renderer.sv
// Turns buffered tile updates into the LCD byte stream for one tile each:
// column window, row window, memory-write command, then the solid colour
// for every pixel. Output byte, dcx and valid are registered.
module tile_renderer
  import snake_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TILE_PX    = 20
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       diff,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_dcx,
  output logic [7:0] out_data,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PIX_N = TILE_PX * TILE_PX;
  localparam int PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_N - 1);
  localparam logic [15:0]      TILE_SPAN = 16'(TILE_PX - 1);

  rend_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             hilo_q, hilo_d;
  logic [3:0]       x_q, x_d;
  logic [3:0]       y_q, y_d;
  logic [15:0]      colour_q, colour_d;
  logic             out_valid_q, out_valid_d;
  logic             out_dcx_q, out_dcx_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             overflow_q, overflow_d;

  logic             push_req, push_ok, pop, accept;
  tile_upd_t        upd_in, upd_head;
  logic [TILE_UPD_W-1:0] fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  assign upd_in   = '{x: x, y: y, obj: obj_code};
  assign upd_head = fifo_rdata;
  assign push_req = diff && (y <= 4'(GRID_H - 1));
  assign push_ok  = push_req && ((fifo_count != CNT_W'(FIFO_DEPTH)) || pop);
  assign accept   = out_valid_q && out_ready;

  tile_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TILE_UPD_W)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push_ok),
    .pop   (pop),
    .wdata (upd_in),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Byte presented in a given position of the tile sequence
  function automatic logic [8:0] lcd_byte(input rend_state_e st, input logic [1:0] idx,
                                          input logic hilo, input logic [3:0] tx,
                                          input logic [3:0] ty, input logic [15:0] col);
    logic [15:0] origin;
    logic [15:0] word;
    origin = 16'((st == ST_CASET_D) ? tx : ty) * 16'(TILE_PX);
    word   = idx[1] ? (origin + TILE_SPAN) : origin;
    case (st)
      ST_CASET_C:             lcd_byte = {1'b0, CMD_CASET};
      ST_RASET_C:             lcd_byte = {1'b0, CMD_RASET};
      ST_RAMWR_C:             lcd_byte = {1'b0, CMD_RAMWR};
      ST_CASET_D, ST_RASET_D: lcd_byte = {1'b1, idx[0] ? word[7:0] : word[15:8]};
      ST_PIXEL:               lcd_byte = {1'b1, hilo ? col[7:0] : col[15:8]};
      default:                lcd_byte = 9'h000;
    endcase
  endfunction

  // Sequencer next state; output byte is derived from the next position
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pix_d      = pix_q;
    hilo_d     = hilo_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (push_req & ~push_ok);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          x_d      = upd_head.x;
          y_d      = upd_head.y;
          colour_d = colour_lut(upd_head.obj);
          state_d  = ST_CASET_C;
        end
      end
      ST_CASET_C: if (accept) begin
        idx_d   = 2'd0;
        state_d = ST_CASET_D;
      end
      ST_CASET_D: if (accept) begin
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = ST_RASET_C;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_RASET_C: if (accept) begin
        idx_d   = 2'd0;
        state_d = ST_RASET_D;
      end
      ST_RASET_D: if (accept) begin
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = ST_RAMWR_C;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_RAMWR_C: if (accept) begin
        pix_d   = '0;
        hilo_d  = 1'b0;
        state_d = ST_PIXEL;
      end
      ST_PIXEL: if (accept) begin
        if (!hilo_q) begin
          hilo_d = 1'b1;
        end else begin
          hilo_d = 1'b0;
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            if (!fifo_empty) begin
              pop      = 1'b1;
              x_d      = upd_head.x;
              y_d      = upd_head.y;
              colour_d = colour_lut(upd_head.obj);
              state_d  = ST_CASET_C;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d != ST_IDLE);
    {out_dcx_d, out_data_d} = lcd_byte(state_d, idx_d, hilo_d, x_d, y_d, colour_d);
  end

  // Sequencer state, latched tile and registered LCD outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pix_q       <= '0;
      hilo_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      out_valid_q <= 1'b0;
      out_dcx_q   <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pix_q       <= pix_d;
      hilo_q      <= hilo_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      out_valid_q <= out_valid_d;
      out_dcx_q   <= out_dcx_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dcx   = out_dcx_q;
  assign out_data  = out_data_q;
  assign full      = fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: byte streams for known tiles with steady
// and random back-pressure, FIFO fill/overflow, off-grid discard, mid-tile reset.
module tb_tile_renderer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       diff = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic [2:0] obj_code = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_dcx;
  logic [7:0] out_data;
  logic       full, busy, overflow;

  int n_vec = 0;
  int n_bad = 0;

  localparam int TILE_BYTES = 811;

  // Hand-computed windows for drain tiles x=0..8, y=0; colours for obj = x
  logic [15:0] dr_x0  [9] = '{16'h0000, 16'h0014, 16'h0028, 16'h003C, 16'h0050,
                              16'h0064, 16'h0078, 16'h008C, 16'h00A0};
  logic [15:0] dr_x1  [9] = '{16'h0013, 16'h0027, 16'h003B, 16'h004F, 16'h0063,
                              16'h0077, 16'h008B, 16'h009F, 16'h00B3};
  logic [15:0] dr_col [9] = '{16'h0000, 16'h07E0, 16'h03E0, 16'hF800, 16'hFFFF,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};

  tile_renderer #(
    .FIFO_DEPTH (8),
    .TILE_PX    (20)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .diff      (diff),
    .x         (x),
    .y         (y),
    .obj_code  (obj_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dcx   (out_dcx),
    .out_data  (out_data),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Header of 11 bytes {dcx,data}, first byte in the top bits
  function automatic logic [98:0] mk_hdr(input logic [15:0] x0, input logic [15:0] x1,
                                         input logic [15:0] y0, input logic [15:0] y1);
    mk_hdr = {9'h02A, 1'b1, x0[15:8], 1'b1, x0[7:0], 1'b1, x1[15:8], 1'b1, x1[7:0],
              9'h02B, 1'b1, y0[15:8], 1'b1, y0[7:0], 1'b1, y1[15:8], 1'b1, y1[7:0],
              9'h02C};
  endfunction

  task automatic send(input logic [3:0] sx, input logic [3:0] sy, input logic [2:0] so);
    @(negedge clk);
    diff = 1'b1; x = sx; y = sy; obj_code = so;
    @(negedge clk);
    diff = 1'b0;
  endtask

  // Consume up to stop_at bytes of one tile, checking each and the hold rule
  task automatic run_tile(input string tag, input logic [98:0] hdr, input logic [15:0] col,
                          input bit rnd, input int stop_at, input bit b2b);
    int          i = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [9:0]  prev = '0;
    logic [9:0]  now_v;
    logic [8:0]  exp;
    while (i < stop_at && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      now_v = {out_valid, out_dcx, out_data};
      if (b2b && cyc == 1) chk({tag, "_b2b_valid"}, 32'(out_valid), 32'd1);
      if (stalled) chk({tag, "_hold"}, 32'(now_v), 32'(prev));
      if (out_valid) begin
        if (out_ready) begin
          if (i < 11) exp = hdr[(10 - i) * 9 +: 9];
          else        exp = {1'b1, ((i - 11) % 2 == 0) ? col[15:8] : col[7:0]};
          chk($sformatf("%s_byte%0d", tag, i), 32'(now_v[8:0]), 32'(exp));
          i++;
        end
        stalled = !out_ready;
        prev    = now_v;
      end else begin
        stalled = 1'b0;
      end
    end
    if (i < stop_at) chk({tag, "_timeout"}, 32'(i), 32'(stop_at));
  endtask

  task automatic idle_checks(input string tag);
    @(negedge clk);
    chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy_after"},  32'(busy),      32'd0);
  endtask

  initial begin
    logic [98:0] h_a, h_b;
    h_a = mk_hdr(16'h003C, 16'h004F, 16'h0028, 16'h003B);
    h_b = mk_hdr(16'h012C, 16'h013F, 16'h00DC, 16'h00EF);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_dcx",      32'(out_dcx),   32'd0);
    chk("rst_data",     32'(out_data),  32'd0);
    chk("rst_full",     32'(full),      32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    nrst = 1'b1;

    // Apple at (3,2), sink always ready
    send(4'd3, 4'd2, 3'b011);
    run_tile("apple", h_a, 16'hF800, 1'b0, TILE_BYTES, 1'b0);
    idle_checks("apple");

    // Border at the far corner (15,11)
    send(4'd15, 4'd11, 3'b100);
    run_tile("corner", h_b, 16'hFFFF, 1'b0, TILE_BYTES, 1'b0);
    idle_checks("corner");

    // Same apple tile under random back-pressure
    send(4'd3, 4'd2, 3'b011);
    run_tile("apple_bp", h_a, 16'hF800, 1'b1, TILE_BYTES, 1'b0);
    idle_checks("apple_bp");

    // Off-grid row is discarded silently
    send(4'd0, 4'd12, 3'b011);
    repeat (3) @(negedge clk);
    chk("offgrid_busy",     32'(busy),      32'd0);
    chk("offgrid_overflow", 32'(overflow),  32'd0);
    chk("offgrid_valid",    32'(out_valid), 32'd0);

    // Ten back-to-back updates into a stalled sink
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      diff = 1'b1; x = 4'(k); y = 4'd0; obj_code = 3'(k % 8);
    end
    @(negedge clk);
    diff = 1'b0;
    chk("burst_full",     32'(full),      32'd1);
    chk("burst_overflow", 32'(overflow),  32'd1);
    chk("burst_busy",     32'(busy),      32'd1);
    chk("burst_first",    32'({out_valid, out_dcx, out_data}), 32'h22A);
    for (int k = 0; k < 9; k++) begin
      run_tile($sformatf("drain%0d", k), mk_hdr(dr_x0[k], dr_x1[k], 16'h0000, 16'h0013),
               dr_col[k], 1'b0, TILE_BYTES, k > 0);
    end
    idle_checks("drain");
    chk("drain_overflow_sticky", 32'(overflow), 32'd1);

    // Reset while pixel 150 is on the bus, then a fresh tile
    send(4'd3, 4'd2, 3'b011);
    run_tile("abort", h_a, 16'hF800, 1'b0, 11 + 150 * 2, 1'b0);
    @(negedge clk);
    chk("abort_pix150_hi", 32'({out_dcx, out_data}), 32'h1F8);
    nrst = 1'b0;
    #1;
    chk("abort_valid_now", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("abort_valid",    32'(out_valid), 32'd0);
    chk("abort_busy",     32'(busy),      32'd0);
    chk("abort_overflow", 32'(overflow),  32'd0);
    nrst = 1'b1;
    send(4'd15, 4'd11, 3'b100);
    run_tile("restart", h_b, 16'hFFFF, 1'b0, TILE_BYTES, 1'b0);
    idle_checks("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
